// File: rtl/tdm_1_n_demux.sv
// Serial-to-parallel TDM demultiplexer: collects x slot bits following a sync
// marker and presents the completed frame with a one-cycle valid strobe.
module tdm_1_n_demux #(
   parameter int n = 2,
   parameter int x = 2**n
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_in,
   input  logic         bit_valid,
   input  logic         sync,
   output logic [x-1:0] data_out,
   output logic         data_valid,
   output logic [n-1:0] s_line,
   output logic         busy,
   output logic         frame_err
);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   localparam logic [n-1:0] LAST_SLOT = n'(x - 1);

   state_t       state;
   logic [x-1:0] shadow;
   logic [x-1:0] merged;

   // Shadow with the current bit already placed, so completion needs no extra cycle
   always_comb begin
      merged         = shadow;
      merged[s_line] = bit_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shadow     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         s_line     <= '0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (bit_valid) begin
            case (state)
               IDLE: begin
                  if (sync) begin
                     if (x == 1) begin
                        data_out   <= x'(bit_in);
                        data_valid <= 1'b1;
                     end else begin
                        shadow[0] <= bit_in;
                        s_line    <= n'(1);
                        state     <= COLLECT;
                        busy      <= 1'b1;
                     end
                  end
               end
               COLLECT: begin
                  if (sync) begin
                     frame_err <= 1'b1;
                     shadow[0] <= bit_in;
                     s_line    <= n'(1);
                  end else if (s_line == LAST_SLOT) begin
                     shadow[s_line] <= bit_in;
                     data_out       <= merged;
                     data_valid     <= 1'b1;
                     s_line         <= '0;
                     state          <= IDLE;
                     busy           <= 1'b0;
                  end else begin
                     shadow[s_line] <= bit_in;
                     s_line         <= s_line + n'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_1_n_demux.sv
// Bench for tdm_1_n_demux: directed scenarios plus random traffic checked
// against a queue-based frame assembly model.
module tb_tdm_1_n_demux;

   localparam int N = 2;
   localparam int X = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         bit_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         sync = 1'b0;
   logic [X-1:0] data_out;
   logic         data_valid;
   logic [N-1:0] s_line;
   logic         busy;
   logic         frame_err;

   tdm_1_n_demux #(.n(N), .x(X)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .sync       (sync),
      .data_out   (data_out),
      .data_valid (data_valid),
      .s_line     (s_line),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned valid_seen = 0;
   int unsigned err_seen   = 0;

   // Reference: bits of the frame in progress, in arrival order
   bit           frame_q[$];
   logic [X-1:0] exp_out = '0;
   logic         exp_valid = 1'b0;
   logic         exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_edge(input logic r, input logic bv, input logic sy, input logic b);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (r) begin
         frame_q.delete();
         exp_out = '0;
      end else if (bv) begin
         if (sy) begin
            if (frame_q.size() > 0) exp_err = 1'b1;
            frame_q.delete();
            frame_q.push_back(b);
         end else if (frame_q.size() > 0) begin
            frame_q.push_back(b);
         end
         if (frame_q.size() == X) begin
            exp_out = '0;
            for (int i = 0; i < X; i++) if (frame_q[i]) exp_out = exp_out | (X'(1) << i);
            exp_valid = 1'b1;
            frame_q.delete();
         end
      end
   endtask

   task automatic step(input logic r, input logic bv, input logic sy, input logic b);
      rst = r; bit_valid = bv; sync = sy; bit_in = b;
      @(posedge clk);
      model_edge(r, bv, sy, b);
      #1;
      check("data_out",   32'(data_out),   32'(exp_out));
      check("data_valid", 32'(data_valid), 32'(exp_valid));
      check("frame_err",  32'(frame_err),  32'(exp_err));
      check("s_line",     32'(s_line),     32'(frame_q.size()));
      check("busy",       32'(busy),       32'(frame_q.size() != 0));
      if (data_valid) valid_seen++;
      if (frame_err) err_seen++;
   endtask

   task automatic send_frame(input logic [X-1:0] w, input int unsigned gaps);
      for (int i = 0; i < X; i++) begin
         step(1'b0, 1'b1, i == 0, w[i]);
         for (int g = 0; g < int'(gaps); g++) begin
            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            check("s_line_hold", 32'(s_line), 32'((i + 1) % X));
         end
      end
   endtask

   initial begin
      // Reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      check("reset_out", 32'(data_out), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // Basic frame 1,0,1,1
      valid_seen = 0;
      step(1'b0, 1'b1, 1'b1, 1'b1); check("basic_s1", 32'(s_line), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0); check("basic_s2", 32'(s_line), 32'd2);
      step(1'b0, 1'b1, 1'b0, 1'b1); check("basic_s3", 32'(s_line), 32'd3);
      check("basic_novalid", 32'(data_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1); check("basic_s0", 32'(s_line), 32'd0);
      check("basic_out", 32'(data_out), 32'hd);
      check("basic_valid", 32'(data_valid), 32'd1);

      // Gapped version of the same frame
      valid_seen = 0;
      send_frame(4'b1101, 3);
      check("gap_out", 32'(data_out), 32'hd);
      check("gap_pulses", valid_seen, 1);

      // Early resync
      valid_seen = 0; err_seen = 0;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("resync_err", 32'(frame_err), 32'd1);
      check("resync_hold", 32'(data_out), 32'hd);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("resync_hold2", 32'(data_out), 32'hd);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("resync_out", 32'(data_out), 32'h6);
      check("resync_errs", err_seen, 1);
      check("resync_pulses", valid_seen, 1);

      // Unsynced bits ignored, then back-to-back frames
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)));
      check("unsync_busy", 32'(busy), 32'd0);
      check("unsync_out", 32'(data_out), 32'h6);
      send_frame(4'hA, 0);
      check("b2b_a", 32'(data_out), 32'hA);
      check("b2b_a_valid", 32'(data_valid), 32'd1);
      send_frame(4'h5, 0);
      check("b2b_5", 32'(data_out), 32'h5);
      check("b2b_5_valid", 32'(data_valid), 32'd1);

      // Reset in mid-frame
      valid_seen = 0; err_seen = 0;
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("midrst_out", 32'(data_out), 32'h0);
      send_frame(4'b0011, 0);
      check("midrst_frame", 32'(data_out), 32'h3);
      check("midrst_pulses", valid_seen, 1);
      check("midrst_errs", err_seen, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(99) == 0), 1'($urandom_range(3) != 0),
              ($urandom_range(5) == 0), 1'($urandom_range(1)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
